uart_tx_param: RTL

Parametrised UART transmitter, the successor to the fixed 8N1 TX used on the IR receiver path. It adds compile-time data width, parity mode and stop-bit count, plus a small input FIFO with a valid/ready handshake, so the NEC decoder can queue several decoded bytes without waiting for each frame. It sits between the decode/packetiser logic and the board UART pin. Frames are sent back to back with no idle gap while the FIFO holds data.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 63 ++++++
 rtl/uart_tx_param.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the parametrised UART transmitter.
//   state_t            - transmitter FSM encoding
//   PAR_NONE/ODD/EVEN  - values accepted by the PARITY parameter
//   CLKS_PER_BIT_9600  - bit period at 100 MHz for 9600 baud
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int CLKS_PER_BIT_9600 = 10417;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO holding words waiting to be transmitted.
//   clk, rst   - clock, synchronous active-high reset
//   push       - write wr_data (ignored while full)
//   wr_data    - word to store
//   pop        - advance the read pointer (ignored while empty)
//   rd_data    - word at the head, valid whenever empty is low
//   full/empty - occupancy flags
//   count      - number of stored words
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the registered count only, so a pop in the same
    // cycle never makes room for a push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmitter with compile-time data width, parity mode
// and stop-bit count, fed through a small FIFO.
//   clk, rst      - clock, synchronous active-high reset
//   i_valid       - write request, accepted when o_ready is high
//   i_data_in     - data word, bit 0 sent first
//   o_ready       - FIFO not full
//   o_tx_serial   - serial line, idles high
//   o_busy        - a frame is in progress
//   o_tx_done     - one-cycle pulse after each frame
//   o_fifo_count  - words waiting in the FIFO
//
// state | meaning
// IDLE  | line high, waiting for a queued word
// START | start bit (0), one bit time
// DATA  | DATA_BITS data bits, LSB first
// PAR   | parity bit, only when PARITY is not PAR_NONE
// STOP  | STOP_BITS stop bits (1); a queued word restarts at START directly
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data_in,
    output logic                 o_ready,
    output logic                 o_tx_serial,
    output logic                 o_busy,
    output logic                 o_tx_done,
    output logic [CW-1:0]        o_fifo_count
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $fatal(1, "uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $fatal(1, "uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $fatal(1, "uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $fatal(1, "uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "uart_tx_param: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CLK_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    state_t               state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;

    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 frame_end;
    logic                 pop;
    logic                 load_par;
    logic                 line_bit;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (i_valid),
        .wr_data (i_data_in),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_fifo_count)
    );

    assign o_ready   = !fifo_full;
    assign bit_end   = (clk_cnt == CLK_LAST);
    assign frame_end = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
    assign pop       = !fifo_empty && ((state == IDLE) || frame_end);

    // Parity is fixed when the word is loaded, before the shift register
    // consumes the data.
    assign load_par = (PARITY == PAR_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;

    always_comb begin
        line_bit = 1'b1;
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shift[0];
            PAR:     line_bit = par_bit;
            default: line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            shift       <= '0;
            par_bit     <= 1'b0;
            o_tx_serial <= 1'b1;
            o_busy      <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            // The line follows the state one cycle later, keeping the pin
            // free of any path from the inputs.
            o_tx_serial <= line_bit;
            o_tx_done   <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (pop) begin
                        shift   <= fifo_rd_data;
                        par_bit <= load_par;
                        o_busy  <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        shift   <= shift >> 1;
                        if (bit_idx == BIT_LAST) begin
                            stop_idx <= 1'b0;
                            state    <= (PARITY != PAR_NONE) ? PAR : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        clk_cnt  <= '0;
                        stop_idx <= 1'b0;
                        state    <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (stop_idx == STOP_LAST) begin
                            o_tx_done <= 1'b1;
                            stop_idx  <= 1'b0;
                            if (pop) begin
                                shift   <= fifo_rd_data;
                                par_bit <= load_par;
                                state   <= START;
                            end else begin
                                o_busy <= 1'b0;
                                state  <= IDLE;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
